// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, parallel load (non-BCD nibbles clamped to 9),
// and either modulo wrap or saturation at the all-0s / all-9s limits.
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcdcount,
    output logic                  wrap,
    output logic                  sat,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] count_reg;
    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] clamp_val;
    logic [DIGITS-1:0]   bad_nibble;
    logic                wrap_reg;
    logic                sat_reg;
    logic                load_err_reg;

    // chain[i] is the carry (up) or borrow (down) entering digit i; chain[DIGITS] set means
    // the counter sits at the limit for the current direction.
    logic [DIGITS:0]     chain;

    assign chain[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] cur;
            logic [3:0] ld;
            logic [3:0] nxt;

            assign cur = count_reg[4*gi +: 4];
            assign ld  = load_val[4*gi +: 4];

            always_comb begin
                nxt = cur;
                if (chain[gi]) begin
                    if (up_dn) nxt = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
                    else       nxt = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
                end
            end

            assign step_val[4*gi +: 4]  = nxt;
            assign chain[gi+1]          = chain[gi] & (up_dn ? (cur == 4'd9) : (cur == 4'd0));
            assign bad_nibble[gi]       = (ld > 4'd9);
            assign clamp_val[4*gi +: 4] = bad_nibble[gi] ? 4'd9 : ld;
        end
    endgenerate

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            count_reg    <= '0;
            wrap_reg     <= 1'b0;
            sat_reg      <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            wrap_reg     <= 1'b0;
            sat_reg      <= 1'b0;
            load_err_reg <= 1'b0;
            if (clr) begin
                count_reg <= '0;
            end else if (load) begin
                count_reg    <= clamp_val;
                load_err_reg <= |bad_nibble;
            end else if (en) begin
                if (!chain[DIGITS]) begin
                    count_reg <= step_val;
                end else if (WRAP) begin
                    count_reg <= step_val;
                    wrap_reg  <= 1'b1;
                end else begin
                    sat_reg <= 1'b1;
                end
            end
        end
    end

    assign bcdcount = count_reg;
    assign wrap     = wrap_reg;
    assign sat      = sat_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: a wrapping and a saturating instance run side by side
// against an integer-arithmetic reference model, plus directed limit/priority cases.
module tb_bcd_updown_counter;

    logic        sclk;
    logic        rst_n;
    logic        en;
    logic        up_dn;
    logic        clr;
    logic        load;
    logic [15:0] load_val;

    logic [15:0] w_cnt, s_cnt;
    logic        w_wrap, w_sat, w_lerr;
    logic        s_wrap, s_sat, s_lerr;

    int tests = 0;
    int fails = 0;

    // Reference state: index 0 = wrapping instance, 1 = saturating instance
    int m_cnt [2];
    bit m_wrap[2];
    bit m_sat [2];
    bit m_lerr[2];

    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b1)) dut_w (
        .sclk(sclk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .bcdcount(w_cnt), .wrap(w_wrap), .sat(w_sat), .load_err(w_lerr)
    );

    bcd_updown_counter #(.DIGITS(4), .WRAP(1'b0)) dut_s (
        .sclk(sclk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .bcdcount(s_cnt), .wrap(s_wrap), .sat(s_sat), .load_err(s_lerr)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int v;
        r = '0;
        v = n;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Applies the documented per-edge rules to a decimal integer count.
    task automatic model_edge();
        int  lv;
        int  pw;
        bit  bad;
        int  nxt;
        lv  = 0;
        pw  = 1;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int nib;
            nib = int'((load_val >> (4*k)) & 16'hF);
            if (nib > 9) begin
                bad = 1'b1;
                nib = 9;
            end
            lv = lv + nib * pw;
            pw = pw * 10;
        end
        for (int m = 0; m < 2; m++) begin
            m_wrap[m] = 1'b0;
            m_sat[m]  = 1'b0;
            m_lerr[m] = 1'b0;
            if (!rst_n || clr) begin
                m_cnt[m] = 0;
            end else if (load) begin
                m_cnt[m]  = lv;
                m_lerr[m] = bad;
            end else if (en) begin
                nxt = up_dn ? m_cnt[m] + 1 : m_cnt[m] - 1;
                if (nxt < 0 || nxt > 9999) begin
                    if (m == 0) begin
                        m_cnt[m]  = (nxt + 10000) % 10000;
                        m_wrap[m] = 1'b1;
                    end else begin
                        m_sat[m] = 1'b1;
                    end
                end else begin
                    m_cnt[m] = nxt;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " w.cnt"},  32'(w_cnt),  32'(to_bcd(m_cnt[0])));
        check({tag, " w.wrap"}, 32'(w_wrap), 32'(m_wrap[0]));
        check({tag, " w.sat"},  32'(w_sat),  32'(m_sat[0]));
        check({tag, " w.lerr"}, 32'(w_lerr), 32'(m_lerr[0]));
        check({tag, " s.cnt"},  32'(s_cnt),  32'(to_bcd(m_cnt[1])));
        check({tag, " s.wrap"}, 32'(s_wrap), 32'(m_wrap[1]));
        check({tag, " s.sat"},  32'(s_sat),  32'(m_sat[1]));
        check({tag, " s.lerr"}, 32'(s_lerr), 32'(m_lerr[1]));
    endtask

    task automatic step(input string tag, input bit r, input bit c, input bit l,
                        input bit e, input bit u, input logic [15:0] lv);
        rst_n    = r;
        clr      = c;
        load     = l;
        en       = e;
        up_dn    = u;
        load_val = lv;
        @(posedge sclk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int wraps;
        int last_wrap;
        logic [15:0] rv;

        rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1; load_val = '0;
        foreach (m_cnt[m]) begin
            m_cnt[m] = 0; m_wrap[m] = 0; m_sat[m] = 0; m_lerr[m] = 0;
        end

        // Reset state
        step("reset", 0, 0, 0, 1, 1, 16'h0000);
        check("reset cnt", 32'(w_cnt), 32'h0);
        check("reset flags", 32'({w_wrap, w_sat, w_lerr, s_sat}), 32'h0);

        // Carry ripples through three digits
        step("ld0999", 1, 0, 1, 0, 1, 16'h0999);
        step("carry", 1, 0, 0, 1, 1, 16'h0000);
        check("carry cnt", 32'(w_cnt), 32'h1000);
        check("carry wrap", 32'(w_wrap), 32'h0);

        // Wrap both ways, one pulse each
        step("ld9999", 1, 0, 1, 0, 1, 16'h9999);
        step("wrap_up", 1, 0, 0, 1, 1, 16'h0000);
        check("wrap_up cnt", 32'(w_cnt), 32'h0000);
        check("wrap_up pulse", 32'(w_wrap), 32'h1);
        step("wrap_dn", 1, 0, 0, 1, 0, 16'h0000);
        check("wrap_dn cnt", 32'(w_cnt), 32'h9999);
        check("wrap_dn pulse", 32'(w_wrap), 32'h1);
        step("hold", 1, 0, 0, 0, 0, 16'h0000);
        check("hold wrap", 32'(w_wrap), 32'h0);

        // Saturation at zero on the non-wrapping instance
        step("ld0000", 1, 0, 1, 0, 0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step("sat_dn", 1, 0, 0, 1, 0, 16'h0000);
            check("sat_dn cnt", 32'(s_cnt), 32'h0000);
            check("sat_dn sat", 32'(s_sat), 32'h1);
            check("sat_dn wrap", 32'(s_wrap), 32'h0);
        end
        step("sat_up", 1, 0, 0, 1, 1, 16'h0000);
        check("sat_up cnt", 32'(s_cnt), 32'h0001);
        check("sat_up sat", 32'(s_sat), 32'h0);

        // Non-BCD load clamps and flags for a single cycle
        step("badload", 1, 0, 1, 0, 1, 16'h3A5F);
        check("badload cnt", 32'(w_cnt), 32'h3959);
        check("badload err", 32'(w_lerr), 32'h1);
        step("after_bad", 1, 0, 0, 0, 1, 16'h0000);
        check("after_bad err", 32'(w_lerr), 32'h0);

        // Priority: clr beats load and en; reset beats load
        step("prio_clr", 1, 1, 1, 1, 1, 16'h5555);
        check("prio_clr cnt", 32'(w_cnt), 32'h0000);
        step("ld1", 1, 0, 1, 0, 1, 16'h0042);
        step("prio_rst", 0, 0, 1, 1, 1, 16'h1234);
        check("prio_rst cnt", 32'(w_cnt), 32'h0000);
        check("prio_rst flags", 32'({w_wrap, w_sat, w_lerr}), 32'h0);

        // Load with en: loaded value taken unmodified
        step("ld_en", 1, 0, 1, 1, 1, 16'h9999);
        check("ld_en cnt", 32'(w_cnt), 32'h9999);
        check("ld_en wrap", 32'(w_wrap), 32'h0);

        // Randomised mix against the reference model
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       rv = 16'($urandom);
                1:       rv = 16'h9999;
                2:       rv = 16'h0000;
                default: rv = to_bcd(int'($urandom_range(0, 9999)));
            endcase
            step("rand", $urandom_range(0, 49) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
                 1'($urandom_range(0, 1)), rv);
        end

        // Free run through the whole range from reset
        step("fr_rst", 0, 0, 0, 0, 1, 16'h0000);
        wraps = 0;
        last_wrap = -1;
        for (int i = 0; i < 10000; i++) begin
            step("free", 1, 0, 0, 1, 1, 16'h0000);
            if (w_wrap) begin
                wraps++;
                last_wrap = i;
            end
        end
        check("free wraps", 32'(wraps), 32'd1);
        check("free last_wrap", 32'(last_wrap), 32'd9999);
        check("free end cnt", 32'(w_cnt), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, number of BCD digits; legal range 1..8.
REQ-002 The block SHALL have parameter WRAP, default 1: 1 = modulo wrap at limits, 0 = saturate at limits.
REQ-003 The block SHALL have port sclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up_dn, input, 1 bit: count direction, 1 = up, 0 = down.
REQ-007 The block SHALL have port clr, input, 1 bit: synchronous clear to zero.
REQ-008 The block SHALL have port load, input, 1 bit: parallel load strobe.
REQ-009 The block SHALL have port load_val, input, 4*DIGITS bits: BCD load value; digit i occupies bits [4i+3:4i], digit 0 least significant.
REQ-010 The block SHALL have port bcdcount, output, 4*DIGITS bits, registered: current count in BCD, same digit packing as load_val.
REQ-011 The block SHALL have port wrap, output, 1 bit, registered: one-cycle pulse on a modulo rollover.
REQ-012 The block SHALL have port sat, output, 1 bit, registered: high while a saturated count is being held (WRAP=0 only).
REQ-013 The block SHALL have port load_err, output, 1 bit, registered: one-cycle pulse when a load contained a non-BCD digit.

Function
REQ-014 Per-edge priority SHALL be: rst_n low, then clr, then load, then en; only the highest active operation takes effect.
REQ-015 When clr=1, bcdcount SHALL become 0 on the next edge and wrap, sat and load_err SHALL be 0 that cycle.
REQ-016 When load=1, each digit SHALL take its load_val nibble; any nibble in the range 10..15 SHALL be clamped to 9.
REQ-017 When load=1 and any nibble of load_val exceeds 9, load_err SHALL be 1 for exactly the following cycle; otherwise load_err SHALL be 0.
REQ-018 When en=1 and up_dn=1, the count SHALL increment by one in decimal: digit 0 goes 9->0 with a carry to the next digit, and carries ripple through all digits within the same cycle.
REQ-019 When en=1 and up_dn=0, the count SHALL decrement by one in decimal: digit 0 goes 0->9 with a borrow, and borrows ripple through all digits within the same cycle.
REQ-020 Every digit of bcdcount SHALL always hold 0..9; no state SHALL ever expose a non-BCD nibble.
REQ-021 Update latency SHALL be one clock: bcdcount reflects the operation on the edge at which it was sampled.
REQ-022 With WRAP=1, counting up from all-9s SHALL give all-0s and counting down from all-0s SHALL give all-9s; wrap SHALL be 1 in the cycle the new value is presented.
REQ-023 With WRAP=0, counting up at all-9s or down at all-0s SHALL leave the count unchanged, set sat=1 and keep wrap=0.
REQ-024 sat SHALL clear on the first edge at which the count changes, a clr or load occurs, or en=0 is sampled.
REQ-025 When en=0 and clr=0 and load=0, bcdcount SHALL hold its value and wrap and load_err SHALL be 0.
REQ-026 A change of up_dn SHALL take effect on the same edge at which it is sampled, with no dead cycle.
REQ-027 When load and en are both asserted, the loaded value SHALL be taken unmodified by the count, and wrap SHALL be 0.

Reset
REQ-028 When rst_n=0 is sampled at a rising edge of sclk, bcdcount, wrap, sat and load_err SHALL all be 0.
REQ-029 Reset SHALL override clr, load and en in the same cycle, including reset asserted in the middle of a carry chain.
REQ-030 The block SHALL resume normal operation on the first edge at which rst_n=1 is sampled.

Verification (DIGITS=4)
REQ-031 The bench SHALL cover up-carry chain: WRAP=1, load 0x0999, then en=1, up_dn=1 for one edge -> bcdcount=0x1000, wrap=0.
REQ-032 The bench SHALL cover wrap both ways: WRAP=1, load 0x9999, up one edge -> 0x0000 and wrap pulses once; then down one edge -> 0x9999 and wrap pulses once.
REQ-033 The bench SHALL cover saturation: WRAP=0, load 0x0000, down for 3 edges -> bcdcount stays 0x0000, sat=1 and wrap=0 throughout; then up one edge -> 0x0001 and sat=0.
REQ-034 The bench SHALL cover invalid load: load_val=0x3A5F -> bcdcount=0x3959, load_err=1 for one cycle.
REQ-035 The bench SHALL cover priority: clr=1, load=1, en=1 together -> bcdcount=0x0000; then rst_n=0 alongside load=1 and load_val=0x1234 -> all outputs 0.
REQ-036 The bench SHALL cover free run: from reset, en=1 up for 10000 edges -> every value 0x0000..0x9999 appears in sequence, with exactly one wrap pulse, on the final edge.
